// File: rtl/axi_sram_slave.sv
// AXI3 slave over a single-ported 32-bit word memory.
// Serves one read or write burst at a time; out-of-range decodes to DECERR.
module axi_sram_slave #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_HI   = 32'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE, RBURST, WDATA, WRESP
  } state_t;

  state_t          r_state;
  logic [3:0]      r_id;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_len;
  logic [7:0]      r_beat;
  logic [1:0]      r_burst;
  logic            r_err;
  logic            r_slverr;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [MEM_WORDS];

  logic            w_ar_hs;
  logic            w_aw_hs;
  logic            w_last;
  logic            w_ren;
  logic            w_we;
  logic            w_ar_err;
  logic            w_aw_err;
  logic [AW-1:0]   w_next;
  logic [AW-1:0]   w_raddr;
  logic            w_unused;

  function automatic logic [AW-1:0] f_next(
    input logic [AW-1:0] a,
    input logic [7:0]    len,
    input logic [1:0]    burst
  );
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    logic          wrap;
    inc  = a + AW'(1);
    mask = AW'(len);
    wrap = (burst == 2'b10) &&
           (len == 8'd1 || len == 8'd3 ||
            len == 8'd7 || len == 8'd15);
    unique case (1'b1)
      burst == 2'b00: f_next = a;
      wrap:           f_next = (a & ~mask) | (inc & mask);
      default:        f_next = inc;
    endcase
  endfunction

  assign w_ar_err = (araddr >> (AW + 2)) != BASE_HI;
  assign w_aw_err = (awaddr >> (AW + 2)) != BASE_HI;
  assign w_ar_hs  = (r_state == IDLE) & arvalid;
  assign w_aw_hs  = (r_state == IDLE) & ~arvalid & awvalid;
  assign w_last   = (r_beat == r_len);
  assign w_next   = f_next(r_addr, r_len, r_burst);
  // Prefetch the next beat on each R handshake so data is ready next cycle.
  assign w_raddr  = (r_state == IDLE) ? araddr[AW+1:2] : w_next;
  assign w_ren    = w_ar_hs |
                    ((r_state == RBURST) & rready & ~w_last);
  assign w_we     = (r_state == WDATA) & wvalid & ~r_err;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          r_mem[r_addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_burst  <= '0;
      r_err    <= 1'b0;
      r_slverr <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_ren) begin
        r_rdata <= r_mem[w_raddr];
      end
      unique case (r_state)
        IDLE: begin
          if (w_ar_hs) begin
            r_id    <= arid;
            r_addr  <= araddr[AW+1:2];
            r_len   <= arlen;
            r_burst <= arburst;
            r_err   <= w_ar_err;
            r_beat  <= '0;
            r_state <= RBURST;
          end else if (w_aw_hs) begin
            r_id     <= awid;
            r_addr   <= awaddr[AW+1:2];
            r_len    <= awlen;
            r_burst  <= awburst;
            r_err    <= w_aw_err;
            r_beat   <= '0;
            r_slverr <= 1'b0;
            r_state  <= WDATA;
          end
        end
        RBURST: begin
          if (rready) begin
            r_beat <= r_beat + 8'd1;
            r_addr <= w_next;
            if (w_last) begin
              r_state <= IDLE;
            end
          end
        end
        WDATA: begin
          if (wvalid) begin
            r_beat <= r_beat + 8'd1;
            r_addr <= w_next;
            if (wlast ^ w_last) begin
              r_slverr <= 1'b1;
            end
            if (wlast | w_last) begin
              r_state <= WRESP;
            end
          end
        end
        WRESP: begin
          if (bready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign arready = resetn & (r_state == IDLE);
  assign awready = resetn & (r_state == IDLE) & ~arvalid;
  assign rvalid  = (r_state == RBURST);
  assign rid     = r_id;
  assign rdata   = r_err ? 32'd0 : r_rdata;
  assign rresp   = (rvalid & r_err) ? 2'b11 : 2'b00;
  assign rlast   = rvalid & w_last;
  assign wready  = (r_state == WDATA);
  assign bvalid  = (r_state == WRESP);
  assign bid     = r_id;
  assign bresp   = !bvalid  ? 2'b00 :
                   r_err    ? 2'b11 :
                   r_slverr ? 2'b10 : 2'b00;

  assign w_unused = ^{arsize, arlock, arcache, arprot, araddr[1:0],
                      awsize, awlock, awcache, awprot, awaddr[1:0],
                      wid};
endmodule
